// File: rtl/agc_pkg.sv
// Shared types for the AGC level-measurement path.
package agc_pkg;

   localparam int DW_DEFAULT = 16;

   typedef logic signed [DW_DEFAULT-1:0] sample_t;
   typedef logic [2*DW_DEFAULT-1:0]      msq_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } rms_state_t;

endpackage

// File: rtl/agc_isqrt_seq.sv
// Sequential restoring integer square root: one result bit per clock, MSB first.
// done is high in the cycle whose rising edge produces the final root bit.
module agc_isqrt_seq
   import agc_pkg::*;
#(
   parameter int OW = DW_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2*OW-1:0] radicand,
   output logic [OW-1:0]   root,
   output logic            done,
   output logic            busy
);

   localparam int CW = (OW > 1) ? $clog2(OW) : 1;

   logic [2*OW-1:0] rad_q, rad_d;
   logic [OW:0]     rem_q, rem_d;
   logic [OW-1:0]   root_q, root_d;
   logic [CW-1:0]   bit_q, bit_d;
   logic            busy_q, busy_d;

   logic [OW+2:0]   rem_sh;
   logic [OW+2:0]   trial;
   logic            take;

   // Remainder never exceeds 2*root, so OW+1 bits hold it between steps.
   assign rem_sh = {rem_q, rad_q[2*OW-1 -: 2]};
   assign trial  = {1'b0, root_q, 2'b01};
   assign take   = (rem_sh >= trial);

   always_comb begin
      rad_d  = rad_q;
      rem_d  = rem_q;
      root_d = root_q;
      bit_d  = bit_q;
      busy_d = busy_q;
      if (start) begin
         rad_d  = radicand;
         rem_d  = '0;
         root_d = '0;
         bit_d  = CW'(OW - 1);
         busy_d = 1'b1;
      end else if (busy_q) begin
         rad_d  = {rad_q[2*OW-3:0], 2'b00};
         rem_d  = take ? (OW+1)'(rem_sh - trial) : (OW+1)'(rem_sh);
         root_d = {root_q[OW-2:0], take};
         bit_d  = bit_q - CW'(1);
         busy_d = (bit_q != '0);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rad_q  <= '0;
         rem_q  <= '0;
         root_q <= '0;
         bit_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rad_q  <= rad_d;
         rem_q  <= rem_d;
         root_q <= root_d;
         bit_q  <= bit_d;
         busy_q <= busy_d;
      end
   end

   assign root = root_q;
   assign done = busy_q && (bit_q == '0);
   assign busy = busy_q;

endmodule

// File: rtl/agc_rms_meter.sv
// Windowed mean-square / RMS level meter for the AGC loop: squares accepted
// samples over 2^LOG2_WIN samples, then takes a sequential integer sqrt.
module agc_rms_meter
   import agc_pkg::*;
#(
   parameter int DW       = DW_DEFAULT,
   parameter int LOG2_WIN = 12,
   parameter int OW       = DW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     x_in,
   input  logic              x_valid,
   input  logic              clr,
   output logic [OW-1:0]     rms_out,
   output logic [2*DW-1:0]   mean_sq,
   output logic              rms_valid,
   output logic              busy
);

   localparam int ACCW = 2*DW + LOG2_WIN;

   if (LOG2_WIN < 5 || LOG2_WIN > 20) begin : g_win_check
      $error("agc_rms_meter: LOG2_WIN must lie in 5..20");
   end
   if (OW != DW) begin : g_ow_check
      $error("agc_rms_meter: OW must equal DW");
   end

   logic signed [2*DW-1:0] x_ext;
   logic [2*DW-1:0]        sq;
   logic [ACCW-1:0]        acc_q, acc_d, acc_sum;
   logic [LOG2_WIN-1:0]    cnt_q, cnt_d;
   logic [2*DW-1:0]        radicand;
   logic [2*DW-1:0]        msq_pend_q;
   logic [OW-1:0]          rms_q;
   logic [2*DW-1:0]        msq_q;
   logic                   valid_q;
   rms_state_t             state_q, state_d;

   logic                   accept;
   logic                   close;
   logic                   out_load;
   logic [OW-1:0]          sq_root;
   logic                   sq_done;
   logic                   sq_busy;

   // Square of the most negative sample is 2^(2DW-2), which still fits unsigned.
   assign x_ext    = (2*DW)'($signed(x_in));
   assign sq       = x_ext * x_ext;
   assign acc_sum  = acc_q + ACCW'(sq);
   assign accept   = x_valid && !clr;
   assign close    = accept && (cnt_q == '1);
   assign radicand = acc_sum[ACCW-1:LOG2_WIN];
   assign out_load = (state_q == DONE) && !clr;

   always_comb begin
      acc_d = acc_q;
      cnt_d = cnt_q;
      if (clr) begin
         acc_d = '0;
         cnt_d = '0;
      end else if (accept) begin
         cnt_d = cnt_q + LOG2_WIN'(1);
         acc_d = close ? '0 : acc_sum;
      end
   end

   always_comb begin
      state_d = state_q;
      if (clr) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:    if (close) state_d = CALC;
            CALC:    if (sq_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   agc_isqrt_seq #(
      .OW(OW)
   ) u_isqrt (
      .clk      (clk),
      .rst      (rst),
      .start    (close),
      .radicand (radicand),
      .root     (sq_root),
      .done     (sq_done),
      .busy     (sq_busy)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_q      <= '0;
         cnt_q      <= '0;
         state_q    <= IDLE;
         msq_pend_q <= '0;
         rms_q      <= '0;
         msq_q      <= '0;
         valid_q    <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         state_q <= state_d;
         if (close) msq_pend_q <= radicand;
         // A clr during DONE discards the pending result.
         if (out_load) begin
            rms_q <= sq_root;
            msq_q <= msq_pend_q;
         end
         valid_q <= out_load;
      end
   end

   assign rms_out   = rms_q;
   assign mean_sq   = msq_q;
   assign rms_valid = valid_q;
   assign busy      = (state_q == CALC) && sq_busy;

endmodule

// File: tb/tb_agc_rms_meter.sv
// Bench for agc_rms_meter: a LOG2_WIN=12 and a LOG2_WIN=5 instance share one input stream.
module tb_agc_rms_meter;
   import agc_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] x_in = '0;
   logic        x_valid = 1'b0;
   logic        clr = 1'b0;

   logic [15:0] rms12, rms5;
   logic [31:0] msq12, msq5;
   logic        rv12, rv5, busy12, busy5;

   int n_checks = 0;
   int n_fail   = 0;
   int spur     = 0;
   bit sb_on    = 1'b0;
   int sb_seen  = 0;

   logic [47:0] exp_q[$];
   logic [7:0]  sine_tbl [256];

   typedef struct {
      logic [15:0] x;
      logic [31:0] msq;
      logic [15:0] rms;
   } vec_t;
   vec_t tbl [5];

   always #5 clk = ~clk;

   agc_rms_meter #(.DW(16), .LOG2_WIN(12), .OW(16)) u_dut12 (
      .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .clr(clr),
      .rms_out(rms12), .mean_sq(msq12), .rms_valid(rv12), .busy(busy12)
   );

   agc_rms_meter #(.DW(16), .LOG2_WIN(5), .OW(16)) u_dut5 (
      .clk(clk), .rst(rst), .x_in(x_in), .x_valid(x_valid), .clr(clr),
      .rms_out(rms5), .mean_sq(msq5), .rms_valid(rv5), .busy(busy5)
   );

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic logic get_rv(input bit big);
      return big ? rv12 : rv5;
   endfunction
   function automatic logic get_busy(input bit big);
      return big ? busy12 : busy5;
   endfunction
   function automatic logic [31:0] get_msq(input bit big);
      return big ? msq12 : msq5;
   endfunction
   function automatic logic [15:0] get_rms(input bit big);
      return big ? rms12 : rms5;
   endfunction

   // Reference integer square root from real arithmetic, then exact correction.
   function automatic longint unsigned isqrt_ref(input longint unsigned m);
      longint unsigned r;
      r = longint'($sqrt(real'(m)));
      while (r * r > m) r--;
      while ((r + 1) * (r + 1) <= m) r++;
      return r;
   endfunction

   function automatic logic [15:0] sine_sample(input int i, input bit quarter);
      int v;
      v = (int'(sine_tbl[i % 256]) - 128) * 256;
      if (quarter) v = v >>> 2;
      return 16'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clr();
      x_valid = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
   endtask

   task automatic feed(input bit big, input logic [15:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         x_in = v;
         x_valid = 1'b1;
         tick();
         if (get_rv(big)) spur++;
      end
      x_valid = 1'b0;
   endtask

   task automatic wait_result(input bit big, input string tag, input logic [31:0] e_msq, input logic [15:0] e_rms);
      int lat;
      x_valid = 1'b0;
      check({tag, "_busy"}, get_busy(big), 1);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (get_rv(big)) begin
            lat = k;
            break;
         end
      end
      check({tag, "_lat"}, lat, 17);
      check({tag, "_msq"}, get_msq(big), e_msq);
      check({tag, "_rms"}, get_rms(big), e_rms);
      tick();
      check({tag, "_pulse"}, get_rv(big), 0);
   endtask

   // Scoreboard for the short-window instance during the random run.
   always @(negedge clk) begin
      if (sb_on && rv5) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected", 1, 0);
         end else begin
            logic [47:0] e;
            e = exp_q.pop_front();
            sb_seen++;
            check("sb_msq", msq5, e[47:16]);
            check("sb_rms", rms5, e[15:0]);
         end
      end
   end

   initial begin
      int pos[$];
      longint unsigned sum, msq;
      int m_cnt, s;
      bit ok;

      for (int i = 0; i < 256; i++)
         sine_tbl[i] = 8'($rtoi(128.0 + 127.0 * $sin(2.0 * 3.14159265358979 * real'(i) / 256.0) + 0.5));
      tbl[0] = '{x: 16'h4000, msq: 32'h1000_0000, rms: 16'd16384};
      tbl[1] = '{x: 16'h8000, msq: 32'h4000_0000, rms: 16'd32768};
      tbl[2] = '{x: 16'h0000, msq: 32'h0000_0000, rms: 16'd0};
      tbl[3] = '{x: 16'h7fff, msq: 32'h3fff_0001, rms: 16'd32767};
      tbl[4] = '{x: 16'hffff, msq: 32'h0000_0001, rms: 16'd1};

      // Reset state
      repeat (3) tick();
      check("rst_rms", rms12, 0);
      check("rst_msq", msq12, 0);
      check("rst_valid", rv12, 0);
      check("rst_busy", busy12, 0);
      check("rst_msq5", msq5, 0);
      rst = 1'b1;
      tick();

      // Constant-input windows
      for (int i = 0; i < 5; i++) begin
         do_clr();
         spur = 0;
         feed(1, tbl[i].x, 4096);
         check($sformatf("tbl%0d_quiet", i), spur, 0);
         wait_result(1, $sformatf("tbl%0d", i), tbl[i].msq, tbl[i].rms);
      end

      // Continuous stream: one pulse per 4096 samples, 17 clocks after each close
      do_clr();
      pos.delete();
      for (int i = 0; i < 8212; i++) begin
         x_in = 16'h4000;
         x_valid = (i < 8192);
         tick();
         if (rv12) pos.push_back(i);
      end
      x_valid = 1'b0;
      check("b2b_count", pos.size(), 2);
      check("b2b_pos0", pos.size() > 0 ? pos[0] : -1, 4112);
      check("b2b_pos1", pos.size() > 1 ? pos[1] : -1, 8208);
      check("b2b_msq", msq12, 32'h1000_0000);

      // Alternating +/-1000 with x_valid toggling
      do_clr();
      spur = 0;
      for (int i = 0; i < 8191; i++) begin
         x_valid = (i % 2 == 0);
         x_in = ((i / 2) % 2) ? 16'($signed(-1000)) : 16'd1000;
         tick();
         if (rv12) spur++;
      end
      check("alt_quiet", spur, 0);
      wait_result(1, "alt", 32'd1000000, 16'd1000);

      // Sine, full and quarter amplitude
      for (int q = 0; q < 2; q++) begin
         do_clr();
         sum = 0;
         for (int i = 0; i < 4096; i++) begin
            x_in = sine_sample(i, q[0]);
            s = int'($signed(x_in));
            sum += longint'(s) * longint'(s);
            x_valid = 1'b1;
            tick();
         end
         x_valid = 1'b0;
         msq = sum >> 12;
         wait_result(1, q ? "sine_q" : "sine", 32'(msq), 16'(isqrt_ref(msq)));
         if (q == 0) ok = (rms12 >= 16'd22973) && (rms12 <= 16'd23005);
         else        ok = (rms12 >= 16'd5739) && (rms12 <= 16'd5755);
         check(q ? "sine_q_tol" : "sine_tol", ok, 1);
      end

      // Short window: 16 x 3 then 16 x 0 -> 144/32 truncates to 4
      do_clr();
      spur = 0;
      feed(0, 16'd3, 16);
      feed(0, 16'd0, 16);
      check("w5_quiet", spur, 0);
      wait_result(0, "w5", 32'd4, 16'd2);

      // Random stream on the short window against the scoreboard
      do_clr();
      m_cnt = 0;
      sum = 0;
      sb_seen = 0;
      sb_on = 1'b1;
      for (int c = 0; c < 600; c++) begin
         x_valid = ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 7))
            0:       x_in = 16'h8000;
            1:       x_in = 16'h7fff;
            default: x_in = 16'($urandom);
         endcase
         tick();
         if (x_valid) begin
            s = int'($signed(x_in));
            sum += longint'(s) * longint'(s);
            m_cnt++;
            if (m_cnt == 32) begin
               msq = sum >> 5;
               exp_q.push_back({32'(msq), 16'(isqrt_ref(msq))});
               m_cnt = 0;
               sum = 0;
            end
         end
      end
      x_valid = 1'b0;
      repeat (25) tick();
      sb_on = 1'b0;
      check("sb_drain", exp_q.size(), 0);
      check("sb_seen_some", sb_seen > 5, 1);

      // clr mid-window restarts the count; the sample offered with clr is dropped
      do_clr();
      spur = 0;
      feed(1, 16'h4000, 1000);
      x_in = 16'h7fff;
      x_valid = 1'b1;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      feed(1, 16'h2000, 4095);
      check("clrwin_quiet", spur, 0);
      feed(1, 16'h2000, 1);
      wait_result(1, "clrwin", 32'h0400_0000, 16'd8192);

      // clr mid-CALC discards the result and keeps the old outputs
      feed(1, 16'h4000, 4096);
      repeat (5) tick();
      check("clrcalc_busy_before", busy12, 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("clrcalc_busy_after", busy12, 0);
      spur = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (rv12) spur++;
      end
      check("clrcalc_no_valid", spur, 0);
      check("clrcalc_rms_kept", rms12, 8192);
      check("clrcalc_msq_kept", msq12, 32'h0400_0000);

      // Async reset mid-CALC clears outputs without a clock edge
      do_clr();
      feed(1, 16'h4000, 4096);
      repeat (5) tick();
      check("rstcalc_busy_before", busy12, 1);
      #2;
      rst = 1'b0;
      #1;
      check("rstcalc_rms", rms12, 0);
      check("rstcalc_msq", msq12, 0);
      check("rstcalc_busy", busy12, 0);
      check("rstcalc_valid", rv12, 0);
      tick();
      tick();
      rst = 1'b1;
      tick();

      // Recovery after reset
      spur = 0;
      feed(0, 16'd3, 16);
      feed(0, 16'd0, 16);
      check("post_rst_quiet", spur, 0);
      wait_result(0, "post_rst", 32'd4, 16'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
